// File: rtl/xtalk_blip_shaper.sv
// Qualifies asynchronous crosstalk sense pulses by width and re-emits each accepted
// event as a fixed-shape clk_blip pulse, with a saturating queue between the two.
module xtalk_blip_shaper #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 1,
  parameter int MAX_WIDTH   = 8,
  parameter int BLIP_HIGH   = 2,
  parameter int BLIP_LOW    = 2,
  parameter int PEND_W      = 4
) (
  input  logic              wb_clk_i,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              victim_in,
  input  logic              clear_flags,
  output logic              clk_blip,
  output logic              event_pulse,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              stuck
);

  localparam int WIDTH_W  = $clog2(MAX_WIDTH + 2);
  localparam int BLIP_MAX = (BLIP_HIGH > BLIP_LOW) ? BLIP_HIGH : BLIP_LOW;
  localparam int BCNT_W   = (BLIP_MAX > 1) ? $clog2(BLIP_MAX) : 1;

  localparam logic [WIDTH_W-1:0] WIDTH_MIN = WIDTH_W'(MIN_WIDTH);
  localparam logic [WIDTH_W-1:0] WIDTH_MAX = WIDTH_W'(MAX_WIDTH);
  localparam logic [WIDTH_W-1:0] WIDTH_LIM = WIDTH_W'(MAX_WIDTH + 1);
  localparam logic [BCNT_W-1:0]  HIGH_END  = BCNT_W'(BLIP_HIGH - 1);
  localparam logic [BCNT_W-1:0]  LOW_END   = BCNT_W'(BLIP_LOW - 1);
  localparam logic [PEND_W-1:0]  PEND_MAX  = '1;

  typedef enum logic [1:0] {M_IDLE, M_MEAS, M_STUCK} m_state_t;
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW}   s_state_t;

  function automatic logic [WIDTH_W-1:0] width_sat_inc(input logic [WIDTH_W-1:0] w);
    if (w >= WIDTH_LIM) return WIDTH_LIM;
    return w + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_p1;
  logic                   s, rise, fall;

  m_state_t               m_state, m_next;
  logic [WIDTH_W-1:0]     width, width_next;
  logic                   ev_next, stuck_set;

  s_state_t               sh_state, sh_next;
  logic [BCNT_W-1:0]      bcnt, bcnt_next;

  logic                   inc, dec, ovf_set;
  logic [PEND_W-1:0]      pend_next;

  // Stage 0: metastability synchroniser, then one-cycle delayed copy for edge detect
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      s_p1    <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], victim_in};
      s_p1    <= s;
    end
  end

  assign s    = sync_p0[SYNC_STAGES-1];
  assign rise = s & ~s_p1;
  assign fall = ~s & s_p1;

  // Stage 1: pulse-width measurement
  always_comb begin
    m_next     = m_state;
    width_next = width;
    ev_next    = 1'b0;
    stuck_set  = 1'b0;
    if (!enable) begin
      m_next     = M_IDLE;
      width_next = '0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (rise) begin
            m_next     = M_MEAS;
            width_next = WIDTH_W'(1);
          end
        end
        M_MEAS: begin
          if (!s) begin
            m_next     = M_IDLE;
            width_next = '0;
            ev_next    = fall && (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
          end else begin
            width_next = width_sat_inc(width);
            if (width == WIDTH_MAX) begin
              m_next    = M_STUCK;
              stuck_set = 1'b1;
            end
          end
        end
        M_STUCK: begin
          if (!s) begin
            m_next     = M_IDLE;
            width_next = '0;
          end
        end
        default: begin
          m_next     = M_IDLE;
          width_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      m_state     <= M_IDLE;
      width       <= '0;
      event_pulse <= 1'b0;
      stuck       <= 1'b0;
    end else begin
      m_state     <= m_next;
      width       <= width_next;
      event_pulse <= ev_next;
      stuck       <= stuck_set | (stuck & ~clear_flags);
    end
  end

  // Stage 2: pending queue; a simultaneous accept and drain leaves the count alone
  assign inc = ev_next;
  assign dec = (sh_state == S_IDLE) && (pending != '0);

  always_comb begin
    pend_next = pending;
    ovf_set   = 1'b0;
    if (inc && !dec) begin
      if (pending == PEND_MAX) ovf_set = 1'b1;
      else                     pend_next = pending + 1'b1;
    end else if (dec && !inc) begin
      pend_next = pending - 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pend_next;
      overflow <= ovf_set | (overflow & ~clear_flags);
    end
  end

  // Stage 3: blip shaper; clk_blip is registered from the state so it cannot glitch
  always_comb begin
    sh_next   = sh_state;
    bcnt_next = bcnt;
    case (sh_state)
      S_IDLE: begin
        if (pending != '0) begin
          sh_next   = S_HIGH;
          bcnt_next = '0;
        end
      end
      S_HIGH: begin
        if (bcnt == HIGH_END) begin
          sh_next   = S_LOW;
          bcnt_next = '0;
        end else begin
          bcnt_next = bcnt + 1'b1;
        end
      end
      S_LOW: begin
        if (bcnt == LOW_END) begin
          sh_next   = S_IDLE;
          bcnt_next = '0;
        end else begin
          bcnt_next = bcnt + 1'b1;
        end
      end
      default: begin
        sh_next   = S_IDLE;
        bcnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sh_state <= S_IDLE;
      bcnt     <= '0;
      clk_blip <= 1'b0;
    end else begin
      sh_state <= sh_next;
      bcnt     <= bcnt_next;
      clk_blip <= (sh_state == S_HIGH);
    end
  end

endmodule

// File: tb/tb_xtalk_blip_shaper.sv
// Directed bench for xtalk_blip_shaper: a default instance plus a MIN_WIDTH=2 instance
// for glitch rejection; expected values are worked out by hand from the cycle timing.
module tb_xtalk_blip_shaper;

  logic       clk = 1'b0;
  logic       rst_n, enable, victim, victim_g, clear_flags;
  logic       blip, ev, ovf, stk;
  logic       blip_g, ev_g, ovf_g, stk_g;
  logic [3:0] pend, pend_g;

  int n_cmp = 0;
  int n_bad = 0;
  int ev_cnt = 0, blip_cnt = 0, ev_cnt_g = 0, blip_cnt_g = 0;
  logic blip_q = 1'b0, blip_gq = 1'b0;
  int e0, b0, seen;

  always #5 clk = ~clk;

  xtalk_blip_shaper dut (
    .wb_clk_i(clk), .reset_n(rst_n), .enable(enable), .victim_in(victim),
    .clear_flags(clear_flags), .clk_blip(blip), .event_pulse(ev),
    .pending(pend), .overflow(ovf), .stuck(stk)
  );

  xtalk_blip_shaper #(.MIN_WIDTH(2)) dut_g (
    .wb_clk_i(clk), .reset_n(rst_n), .enable(enable), .victim_in(victim_g),
    .clear_flags(clear_flags), .clk_blip(blip_g), .event_pulse(ev_g),
    .pending(pend_g), .overflow(ovf_g), .stuck(stk_g)
  );

  always @(negedge clk) begin
    if (ev) ev_cnt <= ev_cnt + 1;
    if (blip && !blip_q) blip_cnt <= blip_cnt + 1;
    blip_q <= blip;
    if (ev_g) ev_cnt_g <= ev_cnt_g + 1;
    if (blip_g && !blip_gq) blip_cnt_g <= blip_cnt_g + 1;
    blip_gq <= blip_g;
  end

  task automatic chk(input string tag, input int obs, input int want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, want);
    end
  endtask

  task automatic pulse(input int w);
    @(negedge clk);
    victim = 1'b1;
    repeat (w) @(negedge clk);
    victim = 1'b0;
  endtask

  task automatic pulse_g(input int w);
    @(negedge clk);
    victim_g = 1'b1;
    repeat (w) @(negedge clk);
    victim_g = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; victim = 1'b0; victim_g = 1'b0; clear_flags = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_blip", blip, 0);
    chk("rst_ev", ev, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_stk", stk, 0);
    chk("rst_g_pend", pend_g, 0);
    chk("rst_g_ovf", ovf_g, 0);
    chk("rst_g_stk", stk_g, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // 3-cycle pulse: event 5 edges after first sample, blip high on samples 7 and 8
    @(negedge clk);
    victim = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk($sformatf("t1_ev[%0d]", k), ev, int'(k == 5));
      chk($sformatf("t1_pend[%0d]", k), pend, int'(k == 5));
      chk($sformatf("t1_blip[%0d]", k), blip, int'(k == 7 || k == 8));
      if (k == 2) victim = 1'b0;
    end

    // MIN_WIDTH=2: 1-cycle glitch rejected, 2-cycle pulse accepted
    e0 = ev_cnt_g; b0 = blip_cnt_g;
    pulse_g(1);
    repeat (12) @(negedge clk);
    chk("t2_glitch_ev", ev_cnt_g - e0, 0);
    chk("t2_glitch_blip", blip_cnt_g - b0, 0);
    chk("t2_glitch_pend", pend_g, 0);
    e0 = ev_cnt_g; b0 = blip_cnt_g;
    pulse_g(2);
    repeat (15) @(negedge clk);
    chk("t2_min_ev", ev_cnt_g - e0, 1);
    chk("t2_min_blip", blip_cnt_g - b0, 1);
    chk("t2_min_pend", pend_g, 0);

    // Stuck detection and the MAX_WIDTH boundary
    e0 = ev_cnt; b0 = blip_cnt;
    pulse(12);
    repeat (6) @(negedge clk);
    chk("t3_stuck12", stk, 1);
    chk("t3_stuck12_ev", ev_cnt - e0, 0);
    chk("t3_stuck12_blip", blip_cnt - b0, 0);
    do_clear();
    chk("t3_clear", stk, 0);
    e0 = ev_cnt; b0 = blip_cnt;
    pulse(8);
    repeat (15) @(negedge clk);
    chk("t3_max_ev", ev_cnt - e0, 1);
    chk("t3_max_blip", blip_cnt - b0, 1);
    chk("t3_max_stk", stk, 0);
    e0 = ev_cnt;
    pulse(9);
    repeat (6) @(negedge clk);
    chk("t3_over_stk", stk, 1);
    chk("t3_over_ev", ev_cnt - e0, 0);
    do_clear();
    chk("t3_clear2", stk, 0);

    // enable dropped mid-pulse aborts the measurement
    e0 = ev_cnt; b0 = blip_cnt;
    @(negedge clk);
    victim = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    victim = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_abort_ev", ev_cnt - e0, 0);
    chk("t6_abort_blip", blip_cnt - b0, 0);
    chk("t6_abort_pend", pend, 0);

    // 30 one-cycle pulses at 2-cycle spacing; events at t=2i, drains at t=1+5k.
    // pending hits 15 at t=48, drops at t=50,54,58 -> 27 accepted.
    e0 = ev_cnt; b0 = blip_cnt;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (j == 26) begin
        chk("t4_pend_sat", pend, 15);
        chk("t4_ovf_before", ovf, 0);
      end
      if (j == 27) begin
        chk("t4_pend_hold", pend, 15);
        chk("t4_ovf_set", ovf, 1);
      end
      if (j == 28) chk("t6_ovf_cleared", ovf, 0);
      if (j == 29) chk("t6_ovf_set_wins", ovf, 1);
      victim = 1'b1;
      clear_flags = 1'b0;
      @(negedge clk);
      victim = 1'b0;
      clear_flags = (j == 27 || j == 28);
    end
    @(negedge clk);
    clear_flags = 1'b0;
    for (int c = 0; c < 200 && pend != 0; c++) @(negedge clk);
    chk("t4_drained", pend, 0);
    repeat (10) @(negedge clk);
    chk("t4_events", ev_cnt - e0, 30);
    chk("t4_blips", blip_cnt - b0, 27);
    chk("t4_ovf_end", ovf, 1);

    // async reset in the middle of a blip
    pulse(12);
    repeat (6) @(negedge clk);
    chk("t5_stuck_pre", stk, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      victim = 1'b1;
      @(negedge clk);
      victim = 1'b0;
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (blip) begin
        seen = 1;
        break;
      end
    end
    chk("t5_blip_seen", seen, 1);
    chk("t5_pend_pre", pend, 1);
    chk("t5_ovf_pre", ovf, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_blip_async", blip, 0);
    chk("t5_pend_async", pend, 0);
    chk("t5_ovf_async", ovf, 0);
    chk("t5_stk_async", stk, 0);
    chk("t5_ev_async", ev, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_pend_after", pend, 0);
    chk("t5_blip_after", blip, 0);
    e0 = ev_cnt; b0 = blip_cnt;
    pulse(3);
    repeat (15) @(negedge clk);
    chk("t5_restart_ev", ev_cnt - e0, 1);
    chk("t5_restart_blip", blip_cnt - b0, 1);
    chk("t5_restart_pend", pend, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
